// File: rtl/tx_seq_recorder_mp_pkg.sv
// Shared types for the TL TX arbiter sequence recorder.
package tx_seq_recorder_mp_pkg;

  localparam int SRC_W        = 3;
  localparam int LANE_BUS_MAX = 256;

  // TLP sources that can win TX arbitration; all-ones marks an idle lane.
  typedef enum logic [SRC_W-1:0] {
    SRC_POSTED    = 3'd0,
    SRC_NONPOSTED = 3'd1,
    SRC_CPL       = 3'd2,
    SRC_CFG       = 3'd3,
    SRC_MSG       = 3'd4,
    SRC_VDM       = 3'd5,
    SRC_DBG       = 3'd6,
    SRC_NONE      = 3'd7
  } Tx_Arbiter_Sources_t;

  localparam Tx_Arbiter_Sources_t NO_SOURCE = SRC_NONE;

  // Packed lane array with every lane set to NO_SOURCE (zero-extended to w).
  function automatic logic [LANE_BUS_MAX-1:0] idle_lanes(input int lanes, input int w);
    logic [LANE_BUS_MAX-1:0] r;
    logic [SRC_W-1:0]        ns;
    r  = '0;
    ns = NO_SOURCE;
    for (int i = 0; i < lanes; i++)
      for (int b = 0; b < w && b < SRC_W; b++)
        r[i*w+b] = ns[b];
    return r;
  endfunction

endpackage

// File: rtl/tx_seq_recorder_mp_if.sv
// Request/response bundle between the TX arbiter and the sequence recorder.
interface tx_seq_recorder_mp_if #(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 16,
  parameter int WR_LANES   = 4,
  parameter int RD_LANES   = 2,
  parameter int CNT_W      = $clog2(DEPTH+1),
  parameter int WC_W       = $clog2(WR_LANES+1),
  parameter int RC_W       = $clog2(RD_LANES+1)
);
  logic                           flush;
  logic                           wr_en;
  logic [WC_W-1:0]                wr_count;
  logic [WR_LANES*DATA_WIDTH-1:0] wr_data;
  logic                           wr_accept;
  logic                           rd_en;
  logic [RC_W-1:0]                rd_count;
  logic                           rd_accept;
  logic [RD_LANES*DATA_WIDTH-1:0] rd_data;
  logic [RD_LANES-1:0]            rd_valid;
  logic [CNT_W-1:0]               occupancy;
  logic [CNT_W-1:0]               available;
  logic                           full;
  logic                           empty;
  logic                           overflow_err;
  logic                           underflow_err;

  modport master (
    output flush, wr_en, wr_count, wr_data, rd_en, rd_count,
    input  wr_accept, rd_accept, rd_data, rd_valid, occupancy, available,
           full, empty, overflow_err, underflow_err
  );

  modport slave (
    input  flush, wr_en, wr_count, wr_data, rd_en, rd_count,
    output wr_accept, rd_accept, rd_data, rd_valid, occupancy, available,
           full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/tx_seq_recorder_mp_seq_ptr_mod_add.sv
// (ptr + step) mod DEPTH for any DEPTH; used for pointer advance and lane slots.
module seq_ptr_mod_add #(
  parameter  int DEPTH  = 16,
  parameter  int STEP_W = 3,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [PTR_W-1:0]  sum_o
);
  localparam int SUM_W = ((PTR_W > STEP_W) ? PTR_W : STEP_W) + 1;

  logic [SUM_W-1:0] sum;

  // Single compare-and-subtract wrap; callers only rely on the result when step <= DEPTH.
  always_comb begin
    sum = SUM_W'(ptr_i) + SUM_W'(step_i);
    if (sum >= SUM_W'(DEPTH)) sum = sum - SUM_W'(DEPTH);
    sum_o = PTR_W'(sum);
  end
endmodule

// File: rtl/tx_seq_recorder_mp.sv
// Multi-port FIFO recording the order in which TLP sources won TX arbitration.
module tx_seq_recorder_mp
  import tx_seq_recorder_mp_pkg::*;
#(
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 16,
  parameter int WR_LANES   = 4,
  parameter int RD_LANES   = 2,
  parameter int CNT_W      = $clog2(DEPTH+1)
) (
  input logic                 clk,
  input logic                 arst,
  tx_seq_recorder_mp_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WC_W  = $clog2(WR_LANES+1);
  localparam int RC_W  = $clog2(RD_LANES+1);
  localparam int RD_BW = RD_LANES*DATA_WIDTH;
  localparam logic [RD_BW-1:0] RD_IDLE = RD_BW'(idle_lanes(RD_LANES, DATA_WIDTH));

  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
  logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CNT_W-1:0]                   occ_q, occ_d, avail;
  logic                               ovf_q, unf_q;
  logic [RD_BW-1:0]                   rd_data_q, rd_data_d;
  logic [RD_LANES-1:0]                rd_valid_q, rd_valid_d;
  logic                               wr_acc, rd_acc;
  logic [WR_LANES-1:0][WC_W-1:0]      wr_lane_idx;
  logic [RD_LANES-1:0][RC_W-1:0]      rd_lane_idx;
  logic [WR_LANES-1:0][PTR_W-1:0]     wr_slot;
  logic [RD_LANES-1:0][PTR_W-1:0]     rd_slot;

  // Acceptance uses start-of-cycle state only: no read frees space for a same-cycle write,
  // and no write feeds a same-cycle read.
  assign avail  = CNT_W'(DEPTH) - occ_q;
  assign wr_acc = bus.wr_en && !bus.flush && (bus.wr_count != '0) &&
                  (32'(bus.wr_count) <= WR_LANES) && (32'(bus.wr_count) <= 32'(avail));
  assign rd_acc = bus.rd_en && !bus.flush && (bus.rd_count != '0) &&
                  (32'(bus.rd_count) <= RD_LANES) && (32'(bus.rd_count) <= 32'(occ_q));

  for (genvar i = 0; i < WR_LANES; i++) begin : g_wl
    assign wr_lane_idx[i] = WC_W'(i);
  end
  for (genvar i = 0; i < RD_LANES; i++) begin : g_rl
    assign rd_lane_idx[i] = RC_W'(i);
  end

  seq_ptr_mod_add #(.DEPTH(DEPTH), .STEP_W(WC_W)) u_wr_adv (
    .ptr_i(wr_ptr_q), .step_i(bus.wr_count), .sum_o(wr_ptr_nxt));
  seq_ptr_mod_add #(.DEPTH(DEPTH), .STEP_W(RC_W)) u_rd_adv (
    .ptr_i(rd_ptr_q), .step_i(bus.rd_count), .sum_o(rd_ptr_nxt));
  seq_ptr_mod_add #(.DEPTH(DEPTH), .STEP_W(WC_W)) u_wr_lane [WR_LANES-1:0] (
    .ptr_i(wr_ptr_q), .step_i(wr_lane_idx), .sum_o(wr_slot));
  seq_ptr_mod_add #(.DEPTH(DEPTH), .STEP_W(RC_W)) u_rd_lane [RD_LANES-1:0] (
    .ptr_i(rd_ptr_q), .step_i(rd_lane_idx), .sum_o(rd_slot));

  // Next pointers, occupancy and read lanes; flush overrides both requests.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    rd_valid_d = '0;
    rd_data_d  = RD_IDLE;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_nxt;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_nxt;
        for (int i = 0; i < RD_LANES; i++) begin
          if (i < int'(bus.rd_count)) begin
            rd_valid_d[i]                       = 1'b1;
            rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_slot[i]];
          end
        end
      end
      occ_d = occ_q + (wr_acc ? CNT_W'(bus.wr_count) : '0)
                    - (rd_acc ? CNT_W'(bus.rd_count) : '0);
    end
  end

  // Control state with asynchronous reset; error flags are sticky until reset.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= RD_IDLE;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      if (bus.wr_en && !bus.flush && !wr_acc) ovf_q <= 1'b1;
      if (bus.rd_en && !bus.flush && !rd_acc) unf_q <= 1'b1;
    end
  end

  // Entry storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_LANES; i++)
      if (wr_acc && i < int'(bus.wr_count))
        mem_q[wr_slot[i]] <= bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.wr_accept     = wr_acc;
  assign bus.rd_accept     = rd_acc;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.occupancy     = occ_q;
  assign bus.available     = avail;
  assign bus.full          = (occ_q == CNT_W'(DEPTH));
  assign bus.empty         = (occ_q == '0);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_tx_seq_recorder_mp.sv
// Drives a DEPTH=16 and a DEPTH=10 recorder with identical stimulus and checks both
// against a queue-based model of the recorder's FIFO rules.
module tb_tx_seq_recorder_mp;
  import tx_seq_recorder_mp_pkg::*;

  localparam int DW = 3, WL = 4, RL = 2, WC_W = 3, RC_W = 2;
  localparam int NONE = 7;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic                 flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [WC_W-1:0]      wr_count = '0;
  logic [RC_W-1:0]      rd_count = '0;
  logic [WL*DW-1:0]     wr_data = '0;

  tx_seq_recorder_mp_if #(.DATA_WIDTH(DW), .DEPTH(16), .WR_LANES(WL), .RD_LANES(RL)) if16 ();
  tx_seq_recorder_mp_if #(.DATA_WIDTH(DW), .DEPTH(10), .WR_LANES(WL), .RD_LANES(RL)) if10 ();

  assign if16.flush = flush;  assign if16.wr_en = wr_en;  assign if16.wr_count = wr_count;
  assign if16.wr_data = wr_data;  assign if16.rd_en = rd_en;  assign if16.rd_count = rd_count;
  assign if10.flush = flush;  assign if10.wr_en = wr_en;  assign if10.wr_count = wr_count;
  assign if10.wr_data = wr_data;  assign if10.rd_en = rd_en;  assign if10.rd_count = rd_count;

  tx_seq_recorder_mp #(.DATA_WIDTH(DW), .DEPTH(16), .WR_LANES(WL), .RD_LANES(RL)) u_dut16 (
    .clk(clk), .arst(arst), .bus(if16.slave));
  tx_seq_recorder_mp #(.DATA_WIDTH(DW), .DEPTH(10), .WR_LANES(WL), .RD_LANES(RL)) u_dut10 (
    .clk(clk), .arst(arst), .bus(if10.slave));

  int               o_occ [2], o_av [2];
  logic             o_full [2], o_empty [2], o_ovf [2], o_unf [2], o_wa [2], o_ra [2];
  logic [RL*DW-1:0] o_rd [2];
  logic [RL-1:0]    o_rv [2];

  always_comb begin
    o_occ[0] = int'(if16.occupancy);  o_av[0] = int'(if16.available);
    o_full[0] = if16.full;  o_empty[0] = if16.empty;
    o_ovf[0] = if16.overflow_err;  o_unf[0] = if16.underflow_err;
    o_wa[0] = if16.wr_accept;  o_ra[0] = if16.rd_accept;
    o_rd[0] = if16.rd_data;  o_rv[0] = if16.rd_valid;
    o_occ[1] = int'(if10.occupancy);  o_av[1] = int'(if10.available);
    o_full[1] = if10.full;  o_empty[1] = if10.empty;
    o_ovf[1] = if10.overflow_err;  o_unf[1] = if10.underflow_err;
    o_wa[1] = if10.wr_accept;  o_ra[1] = if10.rd_accept;
    o_rd[1] = if10.rd_data;  o_rv[1] = if10.rd_valid;
  end

  // Reference model: one queue per DUT plus expected registered read lanes.
  int          dep [2] = '{16, 10};
  int          mq [2][$];
  logic        m_ovf [2], m_unf [2];
  logic [RL-1:0] m_rv [2];
  int          m_rd [2][RL];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    mq[d].delete();
    m_ovf[d] = 1'b0;
    m_unf[d] = 1'b0;
    m_rv[d]  = '0;
    for (int l = 0; l < RL; l++) m_rd[d][l] = NONE;
  endtask

  task automatic check_state(input int d);
    string            p;
    logic [RL*DW-1:0] er;
    p = (d == 0) ? "d16" : "d10";
    for (int l = 0; l < RL; l++) er[l*DW +: DW] = DW'(m_rd[d][l]);
    chk({p, ".occupancy"}, 64'(o_occ[d]), 64'(mq[d].size()));
    chk({p, ".available"}, 64'(o_av[d]), 64'(dep[d] - mq[d].size()));
    chk({p, ".full"}, 64'(o_full[d]), 64'(mq[d].size() == dep[d]));
    chk({p, ".empty"}, 64'(o_empty[d]), 64'(mq[d].size() == 0));
    chk({p, ".overflow_err"}, 64'(o_ovf[d]), 64'(m_ovf[d]));
    chk({p, ".underflow_err"}, 64'(o_unf[d]), 64'(m_unf[d]));
    chk({p, ".rd_valid"}, 64'(o_rv[d]), 64'(m_rv[d]));
    chk({p, ".rd_data"}, 64'(o_rd[d]), 64'(er));
  endtask

  task automatic model_step(input int d);
    string p;
    int    room, sz;
    bit    wa, ra;
    p    = (d == 0) ? "d16" : "d10";
    sz   = mq[d].size();
    room = dep[d] - sz;
    wa = wr_en && !flush && wr_count >= 1 && wr_count <= WL && int'(wr_count) <= room;
    ra = rd_en && !flush && rd_count >= 1 && rd_count <= RL && int'(rd_count) <= sz;
    chk({p, ".wr_accept"}, 64'(o_wa[d]), 64'(wa));
    chk({p, ".rd_accept"}, 64'(o_ra[d]), 64'(ra));
    m_rv[d] = '0;
    for (int l = 0; l < RL; l++) m_rd[d][l] = NONE;
    if (flush) begin
      mq[d].delete();
    end else begin
      if (ra)
        for (int l = 0; l < int'(rd_count); l++) begin
          m_rd[d][l] = mq[d].pop_front();
          m_rv[d][l] = 1'b1;
        end
      if (wa)
        for (int l = 0; l < int'(wr_count); l++) mq[d].push_back(int'(wr_data[l*DW +: DW]));
      if (wr_en && !wa) m_ovf[d] = 1'b1;
      if (rd_en && !ra) m_unf[d] = 1'b1;
    end
  endtask

  // One clock: drive at negedge, check state and accepts, advance model, return after posedge.
  task automatic cyc(input bit fl, input bit we, input int wc, input logic [WL*DW-1:0] wd,
                     input bit re, input int rc);
    @(negedge clk);
    flush = fl; wr_en = we; wr_count = WC_W'(wc); wr_data = wd; rd_en = re; rd_count = RC_W'(rc);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_state(d);
      model_step(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, 0, 0);
  endtask

  task automatic rand_cyc();
    cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70, $urandom_range(0, 7),
        WL*DW'($urandom), $urandom_range(0, 99) < 60, $urandom_range(0, 3));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) model_reset(d);
    #12;
    for (int d = 0; d < 2; d++) check_state(d);
    @(negedge clk);
    arst = 1'b1;

    // Basic order
    cyc(0, 1, 4, {3'd4, 3'd3, 3'd2, 3'd1}, 0, 0);
    cyc(0, 0, 0, '0, 1, 2);
    chk("basic.rd0", 64'(if16.rd_data), 64'(6'b010_001));
    chk("basic.rv0", 64'(if16.rd_valid), 64'(2'b11));
    cyc(0, 0, 0, '0, 1, 2);
    chk("basic.rd1", 64'(if16.rd_data), 64'(6'b100_011));
    chk("basic.rv1", 64'(if16.rd_valid), 64'(2'b11));
    idle();
    chk("basic.empty", 64'(if16.empty), 64'd1);
    chk("basic.avail", 64'(if16.available), 64'd16);

    // Wrap across the end of the non-power-of-two store
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 3, WL*DW'($urandom), 0, 0);
      cyc(0, 0, 0, '0, 1, 2);
    end
    for (int k = 0; k < 8 && mq[0].size() > 0; k++)
      cyc(0, 0, 0, '0, 1, (mq[0].size() >= 2) ? 2 : 1);
    chk("wrap.drained", 64'(if10.occupancy), 64'd0);

    // Full boundary
    cyc(1, 0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 4, WL*DW'($urandom), 0, 0);
    cyc(0, 1, 2, WL*DW'($urandom), 0, 0);
    chk("full.occ14", 64'(if16.occupancy), 64'd14);
    cyc(0, 1, 3, WL*DW'($urandom), 0, 0);
    chk("full.rej_occ", 64'(if16.occupancy), 64'd14);
    chk("full.ovf", 64'(if16.overflow_err), 64'd1);
    cyc(0, 1, 2, WL*DW'($urandom), 0, 0);
    chk("full.full", 64'(if16.full), 64'd1);

    // Write and read together at full
    cyc(0, 1, 1, WL*DW'($urandom), 1, 2);
    chk("fullrw.occ", 64'(if16.occupancy), 64'd14);
    chk("fullrw.ovf", 64'(if16.overflow_err), 64'd1);

    // Empty boundary, no write-to-read bypass
    cyc(1, 0, 0, '0, 0, 0);
    cyc(0, 1, 1, 12'd5, 1, 1);
    chk("empty.unf", 64'(if16.underflow_err), 64'd1);
    chk("empty.occ", 64'(if16.occupancy), 64'd1);
    cyc(0, 0, 0, '0, 1, 1);
    chk("empty.rd", 64'(if16.rd_data), 64'(6'b111_101));
    chk("empty.rv", 64'(if16.rd_valid), 64'(2'b01));

    // Flush beats a same-cycle write and keeps the error flags
    cyc(0, 1, 4, WL*DW'($urandom), 0, 0);
    cyc(0, 1, 3, WL*DW'($urandom), 0, 0);
    chk("flush.occ7", 64'(if16.occupancy), 64'd7);
    cyc(1, 1, 2, WL*DW'($urandom), 0, 0);
    chk("flush.occ0", 64'(if16.occupancy), 64'd0);
    chk("flush.ovf", 64'(if16.overflow_err), 64'd1);
    chk("flush.unf", 64'(if16.underflow_err), 64'd1);
    idle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) rand_cyc();

    // Asynchronous reset in the middle of a burst
    cyc(0, 1, 4, WL*DW'($urandom), 0, 0);
    @(negedge clk);
    wr_en = 1'b1; wr_count = 3'd2; rd_en = 1'b1; rd_count = 2'd1;
    #2;
    arst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      check_state(d);
    end
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_count = '0; rd_count = '0;
    @(negedge clk);
    arst = 1'b1;
    for (int k = 0; k < 40; k++) rand_cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_state(d);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
